// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner.
//   kp_state_e : scanner FSM states
//   clog2      : ceiling log2 usable in constant expressions
//   idx_w      : bits needed to index n items, never less than 1
//   key_w      : width of the linear key code for a ROWS x COLS matrix
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned key_w(input int unsigned rows, input int unsigned cols);
        return idx_w(rows * cols);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Column dwell divider: counts 0..SCAN_DIV-1 and flags the last dwell cycle.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous restart of the dwell count
//   strobe_c   : high during the last cycle of each dwell
module scan_tick
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic strobe_c
);

    localparam int unsigned DIV_W = idx_w(SCAN_DIV);

    logic [DIV_W-1:0] div_q;

    assign strobe_c = (div_q == DIV_W'(SCAN_DIV - 1));

    // Free-running dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (clr || strobe_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with press/release debounce and valid/ready key output.
//   clk, rst_n          : clock, async active-low reset
//   rows                : row sense, low = closed key in the driven column
//   cols                : column drive, exactly one bit low
//   key_code/key_valid  : accepted key index (row*COLS+col), held until key_ready
//   key_ready           : consumer accepts key_code
//   key_down            : accepted key still held
//   overrun / ovr_clr   : sticky dropped-key flag and its synchronous clear
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int unsigned ROWS     = 4,
    parameter  int unsigned COLS     = 4,
    parameter  int unsigned SCAN_DIV = 4,
    parameter  int unsigned DEBOUNCE = 3,
    localparam int unsigned KEY_W    = key_w(ROWS, COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  rows,
    output logic [COLS-1:0]  cols,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_down,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int unsigned ROW_W  = idx_w(ROWS);
    localparam int unsigned COL_W  = idx_w(COLS);
    localparam int unsigned CONF_W = idx_w(DEBOUNCE + 1);

    kp_state_e         state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [COLS-1:0]   cols_q;
    logic [KEY_W-1:0]  key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_down_q, key_down_d;
    logic              overrun_q, overrun_d;

    logic              tick_c;
    logic              tick_clr_c;
    logic              accept_c;
    logic              any_low_c;
    logic [ROW_W-1:0]  low_row_c;
    logic [COL_W-1:0]  next_col_c;
    logic [KEY_W-1:0]  new_code_c;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr_c),
        .strobe_c (tick_c)
    );

    assign any_low_c  = ~&rows;
    assign next_col_c = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
    assign new_code_c = KEY_W'(row_q) * KEY_W'(COLS) + KEY_W'(col_q);

    // Lowest-numbered closed row wins.
    always_comb begin
        low_row_c = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (!rows[i]) low_row_c = ROW_W'(i);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        conf_d      = conf_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q & ~key_ready;
        key_down_d  = key_down_q;
        overrun_d   = overrun_q & ~ovr_clr;
        accept_c    = 1'b0;
        tick_clr_c  = 1'b0;

        case (state_q)
            SCAN: begin
                if (tick_c) begin
                    if (any_low_c) begin
                        row_d   = low_row_c;
                        conf_d  = '0;
                        state_d = DEB_PRESS;
                    end else begin
                        col_d = next_col_c;
                    end
                end
            end
            DEB_PRESS: begin
                if (tick_c) begin
                    if (!rows[row_q]) begin
                        if (conf_q >= CONF_W'(DEBOUNCE - 1)) begin
                            accept_c = 1'b1;
                            conf_d   = '0;
                            state_d  = HELD;
                        end else begin
                            conf_d = conf_q + CONF_W'(1);
                        end
                    end else begin
                        conf_d  = '0;
                        col_d   = next_col_c;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                // Release commits on the all-high sample that sees the saturated count.
                if (tick_c) begin
                    if (any_low_c) begin
                        conf_d = '0;
                    end else if (conf_q >= CONF_W'(DEBOUNCE)) begin
                        conf_d  = '0;
                        state_d = DEB_REL;
                    end else begin
                        conf_d = conf_q + CONF_W'(1);
                    end
                end
            end
            DEB_REL: begin
                // Restart the dwell so the new column gets a full settling period.
                key_down_d = 1'b0;
                col_d      = next_col_c;
                tick_clr_c = 1'b1;
                state_d    = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        if (accept_c) begin
            key_down_d = 1'b1;
            if (!key_valid_q || key_ready) begin
                key_code_d  = new_code_c;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= '0;
            row_q       <= '0;
            conf_q      <= '0;
            cols_q      <= ~COLS'(1);
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            conf_q      <= conf_d;
            cols_q      <= ~(COLS'(1) << col_q);
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner with debounce and a valid/ready key-code output. It drives one active-low column at a time and samples the active-low row inputs. A press is accepted only after it stays stable for a configurable number of scan samples, and is then encoded as a linear key index. The block sits between the keypad pins and the SPI/host-side logic, replacing the free-running 4x4 scanner with an interface that handles arbitrary matrix size and applies backpressure.

## Interface
- ROWS, 4, number of row inputs (>= 1)
- COLS, 4, number of column drives (>= 2)
- SCAN_DIV, 4, clocks per column dwell; rows sampled on last dwell cycle (>= 2)
- DEBOUNCE, 3, consecutive confirming samples for press and for release (>= 1)
- KEY_W, derived, max(1, clog2(ROWS*COLS)); not overridable
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rows  in  ROWS  row sense, low = key closed in driven column
- cols  out  COLS  column drive, exactly one bit low
- key_code  out  KEY_W  row*COLS + col of accepted key
- key_valid  out  1  key_code valid; held until key_ready
- key_ready  in  1  consumer accepts key_code
- key_down  out  1  high while accepted key is held (HELD state)
- overrun  out  1  sticky: an accepted key was dropped
- ovr_clr  in  1  synchronous clear of overrun

## Operation
- Tick: divider counts 0..SCAN_DIV-1. The sample strobe fires at SCAN_DIV-1. Rows are registered only on the strobe.
- SCAN:
  - On a strobe with all rows high, advance the column index, wrapping COLS-1 -> 0.
  - On a strobe with any row low, latch col_idx and row_idx, taking the lowest-numbered low row. Go to DEB_PRESS. The column holds.
- DEB_PRESS:
  - On each strobe, if rows[row_idx] is low, increment conf.
  - When conf reaches DEBOUNCE, accept the key and go to HELD.
  - If rows[row_idx] is high on any strobe, clear conf, advance the column, and return to SCAN.
- Accept:
  - If key_valid is low, or key_valid and key_ready are both high on the same edge, load key_code and keep or set key_valid high.
  - Otherwise leave key_code unchanged and set overrun.
  - Acceptance always enters HELD and sets key_down.
- HELD: the column holds. A strobe with all rows high increments conf; any low row clears conf. At DEBOUNCE, go to DEB_REL.
- DEB_REL: a single transit state. Clear key_down, advance the column, go to SCAN.
- Handshake: key_valid falls on the edge where key_ready is high, unless a new key is accepted on that same edge.
- overrun: cleared by ovr_clr. If set and clear coincide, set wins.
- Arithmetic: key_code = row_idx*COLS + col_idx at KEY_W bits. conf is wide enough for DEBOUNCE, and saturates.

## Timing
- Reset values:
  - state = SCAN, col_idx = 0, divider = 0, conf = 0
  - cols = all ones except bit 0 low
  - key_code = 0, key_valid = 0, key_down = 0, overrun = 0
- Reset mid-operation returns immediately to these values. Reset is asynchronous, with synchronous deassertion assumed upstream.
- cols is a registered decode of col_idx and changes on the edge after a strobe.
- Press latency: key_valid and key_down rise DEBOUNCE*SCAN_DIV clocks after the detecting-strobe edge.
- Release latency: key_down falls DEBOUNCE*SCAN_DIV+1 clocks after the first all-high strobe.
- Minimum dwell per column is SCAN_DIV clocks. A full scan takes COLS*SCAN_DIV clocks with no key pressed.
- Multiple keys in different columns: first column scanned wins. Others are ignored until release.

## Structure
- keypad_pkg holds:
  - state enum {SCAN, DEB_PRESS, HELD, DEB_REL}
  - clog2 function
  - KEY_W computation helper
- Sub-module scan_tick: parametrised SCAN_DIV divider with async active-low reset, producing the one-cycle strobe. Everything else is one FSM module.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3.
- Reset, no key pressed -> cols steps 1110, 1101, 1011, 0111, 1110 every 4 clocks; key_valid=0, overrun=0.
- rows[2] low while cols=1101, held 20 samples -> key_code=9, key_valid rises 12 clocks after the detecting strobe, cols frozen at 1101, key_down=1.
- Release -> key_down=0 13 clocks after the first all-high strobe; cols then shows 1011.
- Bounce: rows[0] low for only 1 strobe -> no key_valid; scan resumes at the next column.
- key_ready=0: press and release key 9, then press key 3 -> overrun=1, key_code stays 9; pulse ovr_clr -> overrun=0.
- Rows 1 and 3 low together in column 0 -> key_code=4.
- Assert rst_n=0 during HELD -> all outputs return to reset values without waiting for a clock edge.
